vend_dispense_arb: RTL
======================

VEND_DISPENSE_ARB -- requirements
Module: vend_dispense_arb

Interface
REQ-001 Parameter TIME_OUT, default 20: cycles allowed in DISP or CHG before fault.
REQ-002 Parameter CNT_W, default 5: timeout counter width.
REQ-003 Parameter STOCK_W, default 6: stock counter width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rstn  in  1  asynchronous active-low reset.
REQ-006 req_pr  in  2  per-channel product request, level, held until done.
REQ-007 req_ch  in  2  per-channel change request, qualified by req_pr of same channel.
REQ-008 disp_done  in  1  dispenser mechanism completion.
REQ-009 chg_done  in  1  change hopper completion.
REQ-010 stock_ld  in  1  load stock counter.
REQ-011 stock_val  in  STOCK_W  stock load value.
REQ-012 fault_clr  in  1  clear fault.
REQ-013 disp_go  out  1  dispenser drive, level.
REQ-014 chg_go  out  1  hopper drive, level.
REQ-015 done  out  2  one-hot, one-cycle completion pulse to served channel.
REQ-016 refused  out  1  valid with done; 1 = served without vending (stock empty).
REQ-017 fault  out  1  sticky timeout fault.
REQ-018 stock  out  STOCK_W  current stock count.
REQ-019 empty  out  1  stock == 0.

Function
REQ-020 States: IDLE, DISP, CHG, ACK, FAULT; registered state, combinational next-state.
REQ-021 IDLE: no req_pr -> stay; one req_pr -> select it; both -> select channel != last_served.
REQ-022 IDLE with selection: latch sel and want_ch = req_ch[sel]; stock == 0 -> ACK with refused = 1; else -> DISP.
REQ-023 req_ch without req_pr is ignored.
REQ-024 DISP: disp_go = 1; disp_done sampled 1 -> stock decrements by 1, next CHG if want_ch else ACK.
REQ-025 CHG: chg_go = 1; chg_done sampled 1 -> ACK.
REQ-026 ACK: done[sel] = 1 for exactly one cycle, refused driven, last_served <= sel, next IDLE.
REQ-027 Requester drops req_pr on the edge that samples done; arbiter resamples requests in IDLE the following cycle.
REQ-028 Timer clears on every state entry and counts each cycle in DISP or CHG; timer == TIME_OUT -> FAULT, no done issued, latched request discarded.
REQ-029 Completion and timeout in same cycle: completion wins.
REQ-030 FAULT: fault = 1, disp_go = chg_go = 0; fault_clr -> IDLE; fault remains 1 until that transition.
REQ-031 stock_ld is honored in any state; it overrides a same-cycle decrement.
REQ-032 Stock never wraps: decrement blocked at 0.
REQ-033 disp_done/chg_done outside their state are ignored.

Reset
REQ-034 rstn low asynchronously forces IDLE, timer 0, stock 0, last_served = 1 (channel 0 first), all outputs 0.
REQ-035 Reset mid-DISP/CHG drops go lines immediately; pending request is not acknowledged.

Structure
REQ-036 State encodings and TIME_OUT/CNT_W/STOCK_W defaults go in shared package vend_pkg.
REQ-037 Round-robin 2-way selection is one sub-module, vend_rr_arb2 (inputs req[1:0], last; output sel, valid).

Verification
REQ-038 Load stock 3; ch0 req_pr only; disp_done 2 cycles after disp_go -> done[0] pulse, refused 0, stock 2.
REQ-039 Both channels req_pr from reset -> ch0 served first, then ch1; ch0 re-requests -> ch0 after ch1 (alternation).
REQ-040 ch1 req_pr + req_ch -> disp_go, then chg_go after disp_done, then done[1]; stock decremented once.
REQ-041 Stock 0, ch0 req_pr -> done[0] with refused 1 two cycles later, disp_go never asserted.
REQ-042 disp_done withheld -> fault at TIME_OUT cycles after DISP entry (20), no done; fault_clr -> IDLE, fault 0.
REQ-043 stock_ld = 10 in the same cycle as disp_done -> stock 10; rstn low mid-CHG -> chg_go 0 without waiting for clk.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and default sizing for the two-channel vending dispense arbiter.
package vend_pkg;

  localparam int TIME_OUT_DEF = 20;
  localparam int CNT_W_DEF    = 5;
  localparam int STOCK_W_DEF  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DISP  = 3'd1,
    ST_CHG   = 3'd2,
    ST_ACK   = 3'd3,
    ST_FAULT = 3'd4
  } vend_state_e;

endpackage

// File: rtl/vend_dispense_arb_if.sv
// Requester, mechanism and stock signals of the dispense arbiter grouped as one bus.
interface vend_dispense_arb_if #(parameter int STOCK_W = vend_pkg::STOCK_W_DEF);
  logic [1:0]         req_pr;
  logic [1:0]         req_ch;
  logic               disp_done;
  logic               chg_done;
  logic               stock_ld;
  logic [STOCK_W-1:0] stock_val;
  logic               fault_clr;
  logic               disp_go;
  logic               chg_go;
  logic [1:0]         done;
  logic               refused;
  logic               fault;
  logic [STOCK_W-1:0] stock;
  logic               empty;

  modport slave (
    input  req_pr, req_ch, disp_done, chg_done, stock_ld, stock_val, fault_clr,
    output disp_go, chg_go, done, refused, fault, stock, empty
  );

  modport master (
    output req_pr, req_ch, disp_done, chg_done, stock_ld, stock_val, fault_clr,
    input  disp_go, chg_go, done, refused, fault, stock, empty
  );
endinterface

// File: rtl/vend_rr_arb2.sv
// Two-way round-robin pick: on contention, the channel not served last wins.
module vend_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       sel,
  output logic       valid
);
  assign valid = |req;
  assign sel   = (&req) ? ~last : req[1];
endmodule

// File: rtl/vend_dispense_arb.sv
// Serves one vend request at a time: dispense, optional change, then a one-cycle done.
module vend_dispense_arb
  import vend_pkg::*;
#(
  parameter int TIME_OUT = TIME_OUT_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STOCK_W  = STOCK_W_DEF
) (
  input logic                 clk,
  input logic                 rstn,
  vend_dispense_arb_if.slave  bus
);

  vend_state_e        state_q, state_d;
  logic [CNT_W-1:0]   tmr_q, tmr_d, tmr_inc;
  logic [STOCK_W-1:0] stock_q, stock_d;
  logic               sel_q, sel_d;
  logic               want_ch_q, want_ch_d;
  logic               refused_q, refused_d;
  logic               last_q, last_d;
  logic               dec;
  logic               arb_sel, arb_vld;

  vend_rr_arb2 u_arb (
    .req   (bus.req_pr),
    .last  (last_q),
    .sel   (arb_sel),
    .valid (arb_vld)
  );

  assign tmr_inc = tmr_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    want_ch_d = want_ch_q;
    refused_d = refused_q;
    last_d    = last_q;
    dec       = 1'b0;
    case (state_q)
      ST_IDLE: if (arb_vld) begin
        sel_d     = arb_sel;
        want_ch_d = bus.req_ch[arb_sel];
        if (stock_q == '0) begin
          refused_d = 1'b1;
          state_d   = ST_ACK;
        end else begin
          refused_d = 1'b0;
          state_d   = ST_DISP;
        end
      end
      // completion is checked before the timer so it wins a same-cycle tie
      ST_DISP: if (bus.disp_done) begin
        dec     = 1'b1;
        state_d = want_ch_q ? ST_CHG : ST_ACK;
      end else if (tmr_inc == CNT_W'(TIME_OUT)) begin
        state_d = ST_FAULT;
      end
      ST_CHG: if (bus.chg_done) state_d = ST_ACK;
              else if (tmr_inc == CNT_W'(TIME_OUT)) state_d = ST_FAULT;
      ST_ACK: begin
        last_d  = sel_q;
        state_d = ST_IDLE;
      end
      ST_FAULT: if (bus.fault_clr) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q)                           tmr_d = '0;
    else if (state_q == ST_DISP || state_q == ST_CHG) tmr_d = tmr_inc;
    else                                              tmr_d = tmr_q;

    stock_d = stock_q;
    if (bus.stock_ld)                  stock_d = bus.stock_val;
    else if (dec && stock_q != '0)     stock_d = stock_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      stock_q   <= '0;
      sel_q     <= 1'b0;
      want_ch_q <= 1'b0;
      refused_q <= 1'b0;
      last_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      stock_q   <= stock_d;
      sel_q     <= sel_d;
      want_ch_q <= want_ch_d;
      refused_q <= refused_d;
      last_q    <= last_d;
    end
  end

  // outputs decode straight from registered state so reset drops them at once
  assign bus.disp_go = (state_q == ST_DISP);
  assign bus.chg_go  = (state_q == ST_CHG);
  assign bus.done    = (state_q == ST_ACK) ? {sel_q, ~sel_q} : 2'b00;
  assign bus.refused = (state_q == ST_ACK) & refused_q;
  assign bus.fault   = (state_q == ST_FAULT);
  assign bus.stock   = stock_q;
  assign bus.empty   = (stock_q == '0);

endmodule
